draw_rect: RTL and testbench

Parametrised rectangle rasteriser: replaces the fixed 4x4 square drawer with a block that draws a rectangle of run-time width and height, filled or outline-only, clipped to the screen. It sits between the game renderer and the VGA adapter's pixel-write port. It accepts one draw command per start/done handshake and emits one pixel per clock in row-major order.

---
 rtl/draw_rect.sv | 159 +++++++++++++++
 tb/tb_draw_rect.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/draw_rect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | draw_rect: one-pixel-per-clock rectangle rasteriser (fill/outline,   |
// | screen-clipped) feeding the VGA adapter pixel-write port. Rev 1.0    |
// +----------------------------------------------------------------------+
module draw_rect #(
  parameter int X_WIDTH      = 9,
  parameter int Y_WIDTH      = 8,
  parameter int COLOUR_WIDTH = 3,
  parameter int SIZE_WIDTH   = 6,
  parameter int SCREEN_W     = 320,
  parameter int SCREEN_H     = 240
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [X_WIDTH-1:0]      x,
  input  logic [Y_WIDTH-1:0]      y,
  input  logic [SIZE_WIDTH-1:0]   w,
  input  logic [SIZE_WIDTH-1:0]   h,
  input  logic [COLOUR_WIDTH-1:0] colour,
  input  logic                    mode,
  output logic                    busy,
  output logic                    done,
  output logic [X_WIDTH-1:0]      vga_x,
  output logic [Y_WIDTH-1:0]      vga_y,
  output logic [COLOUR_WIDTH-1:0] vga_colour,
  output logic                    vga_write
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [X_WIDTH:0]    c_screen_w = (X_WIDTH+1)'(SCREEN_W);
  localparam logic [Y_WIDTH:0]    c_screen_h = (Y_WIDTH+1)'(SCREEN_H);
  localparam logic [SIZE_WIDTH-1:0] c_one    = SIZE_WIDTH'(1);

  state_t                  state_q, state_d;
  logic [X_WIDTH-1:0]      x_q, x_d;
  logic [Y_WIDTH-1:0]      y_q, y_d;
  logic [SIZE_WIDTH-1:0]   w_q, w_d;
  logic [SIZE_WIDTH-1:0]   h_q, h_d;
  logic                    mode_q, mode_d;
  logic [SIZE_WIDTH-1:0]   col_q, col_d;
  logic [SIZE_WIDTH-1:0]   row_q, row_d;
  logic                    done_q, done_d;
  logic [X_WIDTH-1:0]      vga_x_q, vga_x_d;
  logic [Y_WIDTH-1:0]      vga_y_q, vga_y_d;
  logic [COLOUR_WIDTH-1:0] vga_colour_q, vga_colour_d;
  logic                    vga_write_q, vga_write_d;

  // One extra bit on the sums so off-screen pixels are detected, not wrapped.
  logic [X_WIDTH:0] sum_x;
  logic [Y_WIDTH:0] sum_y;
  logic             last_col, last_row, clipped, on_border;

  assign sum_x     = {1'b0, x_q} + (X_WIDTH+1)'(col_q);
  assign sum_y     = {1'b0, y_q} + (Y_WIDTH+1)'(row_q);
  assign last_col  = (col_q == w_q - c_one);
  assign last_row  = (row_q == h_q - c_one);
  assign clipped   = (sum_x >= c_screen_w) || (sum_y >= c_screen_h);
  assign on_border = (col_q == '0) || last_col || (row_q == '0) || last_row;

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    w_d          = w_q;
    h_d          = h_q;
    mode_d       = mode_q;
    col_d        = col_q;
    row_d        = row_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    done_d       = 1'b0;
    vga_write_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          x_d          = x;
          y_d          = y;
          w_d          = w;
          h_d          = h;
          mode_d       = mode;
          vga_colour_d = colour;
          col_d        = '0;
          row_d        = '0;
          state_d      = ((w != '0) && (h != '0)) ? DRAW : DONE;
        end
      end
      DRAW: begin
        vga_x_d     = sum_x[X_WIDTH-1:0];
        vga_y_d     = sum_y[Y_WIDTH-1:0];
        vga_write_d = !clipped && (!mode_q || on_border);
        if (last_col) begin
          col_d = '0;
          if (last_row) begin
            state_d = DONE;
          end else begin
            row_d = row_q + c_one;
          end
        end else begin
          col_d = col_q + c_one;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      w_q          <= '0;
      h_q          <= '0;
      mode_q       <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      done_q       <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_write_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      w_q          <= w_d;
      h_q          <= h_d;
      mode_q       <= mode_d;
      col_q        <= col_d;
      row_q        <= row_d;
      done_q       <= done_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_write_q  <= vga_write_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_write  = vga_write_q;

endmodule
`default_nettype wire

// File: tb/tb_draw_rect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_draw_rect: randomized and directed bench for draw_rect against a  |
// | per-cycle pixel model. Rev 1.0                                       |
// +----------------------------------------------------------------------+
module tb_draw_rect;

  localparam int XW = 9;
  localparam int YW = 8;
  localparam int CW = 3;
  localparam int SW = 6;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [XW-1:0] x = '0;
  logic [YW-1:0] y = '0;
  logic [SW-1:0] w = '0;
  logic [SW-1:0] h = '0;
  logic [CW-1:0] colour = '0;
  logic          mode = 1'b0;
  logic          busy, done, vga_write;
  logic [XW-1:0] vga_x;
  logic [YW-1:0] vga_y;
  logic [CW-1:0] vga_colour;

  draw_rect dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .x          (x),
    .y          (y),
    .w          (w),
    .h          (h),
    .colour     (colour),
    .mode       (mode),
    .busy       (busy),
    .done       (done),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_write  (vga_write)
  );

  always #5 clock = ~clock;

  typedef struct {
    int px, py, pw, ph, pc, pm;
  } cmd_t;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference rule for one scanned pixel of a command.
  function automatic bit model_write(input cmd_t c, input int col, input int row);
    int  sx = c.px + col;
    int  sy = c.py + row;
    bit  clip = (sx >= 320) || (sy >= 240);
    bit  border = (col == 0) || (col == c.pw - 1) || (row == 0) || (row == c.ph - 1);
    return !clip && (c.pm == 0 || border);
  endfunction

  function automatic cmd_t mk(input int px, input int py, input int pw, input int ph,
                              input int pc, input int pm);
    cmd_t c;
    c.px = px; c.py = py; c.pw = pw; c.ph = ph; c.pc = pc; c.pm = pm;
    return c;
  endfunction

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.px = $urandom_range(0, 511);
    c.py = $urandom_range(0, 255);
    c.pw = ($urandom_range(0, 15) == 0) ? $urandom_range(40, 63) : $urandom_range(0, 12);
    c.ph = $urandom_range(0, 12);
    c.pc = $urandom_range(0, 7);
    c.pm = $urandom_range(0, 1);
    if ($urandom_range(0, 3) == 0) begin
      c.px = $urandom_range(300, 319);
      c.py = $urandom_range(225, 239);
    end
    return c;
  endfunction

  task automatic scramble_inputs();
    x      = XW'($urandom);
    y      = YW'($urandom);
    w      = SW'($urandom);
    h      = SW'($urandom);
    colour = CW'($urandom);
    mode   = 1'($urandom);
  endtask

  // Called at a negedge: presents the command with start high.
  task automatic apply(input cmd_t c);
    x      = XW'(c.px);
    y      = YW'(c.py);
    w      = SW'(c.pw);
    h      = SW'(c.ph);
    colour = CW'(c.pc);
    mode   = 1'(c.pm);
    start  = 1'b1;
  endtask

  // Checks cycles 0..N+1 of a command applied just before; returns at the
  // negedge of cycle N+1 so the caller may present a back-to-back command.
  task automatic run(input cmd_t c, input bit hold, input int abort_at);
    int n = c.pw * c.ph;
    int nwr = 0;
    int expw = 0;
    @(posedge clock);
    for (int k = 0; k <= n + 1; k++) begin
      @(negedge clock);
      if (k == 0) begin
        check($sformatf("busy@%0d", k), busy, 1);
        check($sformatf("write@%0d", k), vga_write, 0);
        check($sformatf("done@%0d", k), done, 0);
      end else if (k <= n) begin
        int col = (k - 1) % c.pw;
        int row = (k - 1) / c.pw;
        bit ew  = model_write(c, col, row);
        expw += ew;
        check($sformatf("busy@%0d", k), busy, 1);
        check($sformatf("done@%0d", k), done, 0);
        check($sformatf("write@%0d", k), vga_write, ew);
        check($sformatf("vga_x@%0d", k), vga_x, (c.px + col) % 512);
        check($sformatf("vga_y@%0d", k), vga_y, (c.py + row) % 256);
      end else begin
        check($sformatf("busy@%0d", k), busy, 0);
        check($sformatf("done@%0d", k), done, 1);
        check($sformatf("write@%0d", k), vga_write, 0);
      end
      check($sformatf("colour@%0d", k), vga_colour, c.pc);
      if (vga_write === 1'b1) nwr++;
      if (k == abort_at) begin
        reset = 1'b1;
        start = 1'b0;
        return;
      end
      if (hold && k <= n) scramble_inputs();
      else start = 1'b0;
    end
    check("write_count", nwr, expw);
  endtask

  task automatic idle_cycles(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      start = 1'b0;
      scramble_inputs();
      @(negedge clock);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_write", vga_write, 0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_write", vga_write, 0);
    check("rst_x", vga_x, 0);
    check("rst_y", vga_y, 0);
    check("rst_colour", vga_colour, 0);
    reset = 1'b0;
    idle_cycles(2);

    apply(mk(10, 20, 4, 4, 5, 0));    run(mk(10, 20, 4, 4, 5, 0), 1'b0, -1);
    apply(mk(0, 0, 5, 3, 6, 1));      run(mk(0, 0, 5, 3, 6, 1), 1'b0, -1);
    apply(mk(318, 238, 4, 4, 3, 0));  run(mk(318, 238, 4, 4, 3, 0), 1'b0, -1);
    apply(mk(50, 60, 0, 7, 2, 0));    run(mk(50, 60, 0, 7, 2, 0), 1'b0, -1);
    apply(mk(77, 88, 1, 1, 4, 1));    run(mk(77, 88, 1, 1, 4, 1), 1'b0, -1);
    idle_cycles(1);
    // Start held and inputs churned mid-draw, then chained start in done cycle.
    apply(mk(100, 100, 3, 2, 7, 0));  run(mk(100, 100, 3, 2, 7, 0), 1'b1, -1);
    apply(mk(200, 150, 3, 2, 1, 1));  run(mk(200, 150, 3, 2, 1, 1), 1'b0, -1);

    // Reset in cycle 5 of an 8x8 draw.
    apply(mk(30, 40, 8, 8, 6, 0));    run(mk(30, 40, 8, 8, 6, 0), 1'b0, 5);
    @(negedge clock);
    check("abort_busy", busy, 0);
    check("abort_write", vga_write, 0);
    check("abort_done", done, 0);
    check("abort_x", vga_x, 0);
    check("abort_y", vga_y, 0);
    check("abort_colour", vga_colour, 0);
    reset = 1'b0;
    idle_cycles(3);
    apply(mk(12, 13, 2, 3, 5, 0));    run(mk(12, 13, 2, 3, 5, 0), 1'b0, -1);

    for (int i = 0; i < 40; i++) begin
      cmd_t c = rand_cmd();
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
      apply(c);
      run(c, 1'($urandom_range(0, 1)), -1);
    end
    idle_cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
